soc_timer_mc: RTL and testbench
===============================

// Module: soc_timer_mc
// PURPOSE
//  Multi-channel Avalon-MM interval timer with per-channel prescaler, one-shot/continuous modes, snapshot and masked IRQ.
//  Sits on the SoC system bus as a slave; its single irq output is routed to the CPU interrupt controller.
//  Generalises the single 32-bit timer to NUM_CH independent channels of COUNT_W bits on a DATA_W-bit bus.
// PARAMETERS
//  NUM_CH      4       channels, 1..8
//  COUNT_W     32      counter/period/snapshot width, 8..32
//  DATA_W      32      bus width, >= COUNT_W
//  PRE_W       8       prescaler width, 1..16
//  RST_PERIOD  9       reset value of every period register and counter
//  CH_AW       $clog2(NUM_CH) (min 1), derived
// PORTS
//  clk         in   1            system clock
//  reset_n     in   1            asynchronous active-low reset
//  address     in   3+CH_AW      [CH_AW+2:3]=channel, [2:0]=register
//  chipselect  in   1            slave select
//  write_n     in   1            active-low write strobe
//  writedata   in   DATA_W       write data
//  readdata    out  DATA_W       registered read data
//  irq         out  1            OR over channels of (TO & ITO)
//  irq_vec     out  NUM_CH       per-channel (TO & ITO)
//  pwm_out     out  NUM_CH       PWM outputs (present only with TIMER_PWM_EN)
// BEHAVIOUR
//  Register map per channel: 0 STATUS {RUN,TO}; 1 CONTROL; 2 PERIOD; 3 SNAPSHOT; 4 COMPARE (PWM only); 5-7 reserved.
//  CONTROL: [0] ITO irq enable, [1] CONT continuous, [2] START, [3] STOP (both write-only pulses, read 0), [8+PRE_W-1:8] PRE.
//  Reset: counter=RST_PERIOD, period=RST_PERIOD, RUN=0, TO=0, CONTROL=0, snapshot=0, prescaler=0, readdata=0, irq=0, pwm_out=0.
//  Read latency: exactly 1 cycle; readdata updates every clock from the mux. Fields zero-extended to DATA_W.
//  Channel index >= NUM_CH or reserved register: reads 0, writes ignored.
//  Prescaler: while RUN, pre_cnt counts 0..PRE; tick asserted in cycle pre_cnt==PRE, then pre_cnt wraps to 0. PRE=0 -> tick every cycle.
//  Counter: on tick, if counter!=0 decrement; if counter==0 -> timeout event, reload period; if CONT=0, RUN clears same edge.
//  Timeout period therefore (PERIOD+1)*(PRE+1) clocks; PERIOD=0 -> timeout every tick.
//  PERIOD write: next edge counter<=writedata[COUNT_W-1:0], pre_cnt<=0, RUN<=0 (timer stops; software must restart).
//  START pulse: RUN<=1, pre_cnt<=0; counter unchanged. STOP pulse: RUN<=0. START and STOP together: START wins.
//  START in same write as PERIOD impossible (different registers); PERIOD write while RUN: stop and load take effect together.
//  STATUS write (any data): clears TO. Timeout event in same cycle as STATUS write: TO stays 1 (set wins).
//  TO is sticky until cleared; irq_vec[i]=TO[i]&ITO[i] combinational from registers; irq=|irq_vec.
//  SNAPSHOT write (any data): snapshot<=counter value of that cycle; read returns snapshot, not live counter.
//  Channels fully independent; simultaneous accesses only via separate bus cycles.
//  Reset asserted mid-count: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  TIMER_PWM_EN defined: per channel COMPARE register (COUNT_W, reset 0) at register 4;
//    pwm_out[i] registered, =1 when RUN & counter<=COMPARE, else 0; COMPARE>=PERIOD -> constant 1 while running.
//  TIMER_PWM_EN undefined: no COMPARE register, register 4 reads 0 and ignores writes, pwm_out port absent.
// TESTING
//  T1 reset -> readdata=0, irq=0; read ch0 PERIOD -> 9 one cycle later; read STATUS -> 0.
//  T2 ch1 PERIOD=4, CONTROL=0x7 (PRE=0,CONT,ITO,START) -> TO every 5 clocks, irq high 1st timeout, STATUS write clears.
//  T3 ch2 PERIOD=2, PRE=3, one-shot START -> single timeout after 12 clocks, RUN=0, counter reloaded to 2.
//  T4 STATUS write coincident with timeout event -> TO remains 1; START+STOP same write -> RUN=1.
//  T5 ch0 running, SNAPSHOT write at counter=7 -> read SNAPSHOT=7 while counter keeps decrementing; ch index NUM_CH reads 0.
//  T6 TIMER_PWM_EN: PERIOD=9, COMPARE=4, CONT -> pwm_out duty 5/10 clocks; without macro reg 4 reads 0.

Source files
------------

// File: rtl/soc_timer_mc.sv
// soc_timer_mc: NUM_CH-channel Avalon-MM interval timer with prescaler, snapshot and masked irq.
// Define TIMER_PWM_EN to add a per-channel COMPARE register (reg 4) and the pwm_out port.
module soc_timer_mc #(
  parameter int NUM_CH     = 4,
  parameter int COUNT_W    = 32,
  parameter int DATA_W     = 32,
  parameter int PRE_W      = 8,
  parameter int RST_PERIOD = 9,
  localparam int CH_AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CH_AW+2:0]    address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                irq,
`ifdef TIMER_PWM_EN
  output logic [NUM_CH-1:0]   irq_vec,
  output logic [NUM_CH-1:0]   pwm_out
`else
  output logic [NUM_CH-1:0]   irq_vec
`endif
);
  logic [CH_AW-1:0]               ch;
  logic [2:0]                     ra;
  logic                           ch_ok, wr, unused_wd;
  logic [COUNT_W-1:0]             wd;
  logic [NUM_CH-1:0][DATA_W-1:0]  rv;
  logic [DATA_W-1:0]              readdata_d;
  assign ch         = address[CH_AW+2:3];
  assign ra         = address[2:0];
  assign wd         = writedata[COUNT_W-1:0];
  assign ch_ok      = 32'(ch) < NUM_CH;
  assign wr         = chipselect & ~write_n & ch_ok;
  assign unused_wd  = ^writedata;
  assign readdata_d = ch_ok ? rv[ch] : '0;
  assign irq        = |irq_vec;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= readdata_d;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [COUNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d, cmp_rd;
    logic [PRE_W-1:0]   pre_q, pre_d, pc_q, pc_d;
    logic               run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic               sel, tick, tev, ctl_wr, per_wr, start, stop;
    assign sel    = wr & (ch == CH_AW'(i));
    assign ctl_wr = sel & (ra == 3'd1);
    assign per_wr = sel & (ra == 3'd2);
    assign start  = ctl_wr & writedata[2];
    assign stop   = ctl_wr & writedata[3];
    assign tick   = run_q & (pc_q == pre_q);
    assign tev    = tick & (cnt_q == '0);
    always_comb begin
      pc_d   = (per_wr | start) ? '0 : run_q ? (tick ? '0 : pc_q + PRE_W'(1)) : pc_q;
      cnt_d  = per_wr ? wd : tick ? (tev ? per_q : cnt_q - COUNT_W'(1)) : cnt_q;
      per_d  = per_wr ? wd : per_q;
      run_d  = per_wr ? 1'b0 : start ? 1'b1 : stop ? 1'b0 : (tev & ~cont_q) ? 1'b0 : run_q;
      to_d   = tev | (to_q & ~(sel & (ra == 3'd0)));
      ito_d  = ctl_wr ? writedata[0] : ito_q;
      cont_d = ctl_wr ? writedata[1] : cont_q;
      pre_d  = ctl_wr ? writedata[8 +: PRE_W] : pre_q;
      snap_d = (sel & (ra == 3'd3)) ? cnt_q : snap_q;
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt_q  <= COUNT_W'(RST_PERIOD);
        per_q  <= COUNT_W'(RST_PERIOD);
        snap_q <= '0;
        pre_q  <= '0;
        pc_q   <= '0;
        run_q  <= 1'b0;
        to_q   <= 1'b0;
        ito_q  <= 1'b0;
        cont_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        snap_q <= snap_d;
        pre_q  <= pre_d;
        pc_q   <= pc_d;
        run_q  <= run_d;
        to_q   <= to_d;
        ito_q  <= ito_d;
        cont_q <= cont_d;
      end
`ifdef TIMER_PWM_EN
    logic [COUNT_W-1:0] cmp_q, cmp_d;
    logic               pwm_q, pwm_d;
    // computed from next state so pwm_out always mirrors the current RUN/counter/COMPARE
    assign cmp_d = (sel & (ra == 3'd4)) ? wd : cmp_q;
    assign pwm_d = run_d & (cnt_d <= cmp_d);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cmp_q <= '0;
        pwm_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        pwm_q <= pwm_d;
      end
    assign cmp_rd     = cmp_q;
    assign pwm_out[i] = pwm_q;
`else
    assign cmp_rd = '0;
`endif
    assign irq_vec[i] = to_q & ito_q;
    assign rv[i] = (ra == 3'd0) ? DATA_W'({run_q, to_q}) :
                   (ra == 3'd1) ? DATA_W'({pre_q, 6'b0, cont_q, ito_q}) :
                   (ra == 3'd2) ? DATA_W'(per_q) :
                   (ra == 3'd3) ? DATA_W'(snap_q) :
                   (ra == 3'd4) ? DATA_W'(cmp_rd) : '0;
  end
endmodule

// File: tb/tb_soc_timer_mc.sv
// tb_soc_timer_mc: randomized and directed bus traffic against a behavioural timer model.
module tb_soc_timer_mc;
  localparam int NC = 3, CW = 16, DW = 32, PW = 4, RP = 9;
  logic          clk = 0, reset_n = 1, chipselect = 0, write_n = 1;
  logic [4:0]    address = '0;
  logic [DW-1:0] writedata = '0, readdata;
  logic          irq;
  logic [NC-1:0] irq_vec;
`ifdef TIMER_PWM_EN
  logic [NC-1:0] pwm_out;
`endif

  soc_timer_mc #(.NUM_CH(NC), .COUNT_W(CW), .DATA_W(DW), .PRE_W(PW), .RST_PERIOD(RP)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
`ifdef TIMER_PWM_EN
    .irq_vec(irq_vec), .pwm_out(pwm_out)
`else
    .irq_vec(irq_vec)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int unsigned m_cnt[NC], m_per[NC], m_pre[NC], m_pc[NC], m_snap[NC], m_cmp[NC];
  bit m_run[NC], m_to[NC], m_ito[NC], m_cont[NC];
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = RP; m_per[c] = RP; m_pre[c] = 0; m_pc[c] = 0; m_snap[c] = 0; m_cmp[c] = 0;
      m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
    end
    exp_rd = 0;
  endfunction

  function automatic logic [31:0] m_read(int ch, int ra);
    if (ch >= NC) return 0;
    case (ra)
      0: return {30'b0, m_run[ch], m_to[ch]};
      1: return (m_pre[ch] << 8) | (32'(m_cont[ch]) << 1) | 32'(m_ito[ch]);
      2: return m_per[ch];
      3: return m_snap[ch];
`ifdef TIMER_PWM_EN
      4: return m_cmp[ch];
`endif
      default: return 0;
    endcase
  endfunction

  // one clock edge: read mux sampled from old state, then counting, then the bus write
  function automatic void m_step(bit cs, bit wn, logic [4:0] a, logic [31:0] wd);
    int ch = int'(a[4:3]);
    int ra = int'(a[2:0]);
    bit wr = cs && !wn && ch < NC;
    exp_rd = m_read(ch, ra);
    for (int c = 0; c < NC; c++) begin
      int unsigned old_cnt = m_cnt[c];
      bit tick = m_run[c] && m_pc[c] == m_pre[c];
      bit tev = tick && m_cnt[c] == 0;
      if (m_run[c]) m_pc[c] = tick ? 0 : (m_pc[c] + 1) % (1 << PW);
      if (tick) m_cnt[c] = tev ? m_per[c] : m_cnt[c] - 1;
      if (tev) begin
        m_to[c] = 1;
        if (!m_cont[c]) m_run[c] = 0;
      end
      if (wr && ch == c)
        case (ra)
          0: if (!tev) m_to[c] = 0;
          1: begin
            m_ito[c] = wd[0]; m_cont[c] = wd[1]; m_pre[c] = wd[11:8];
            if (wd[2]) begin m_run[c] = 1; m_pc[c] = 0; end
            else if (wd[3]) m_run[c] = 0;
          end
          2: begin m_per[c] = wd[15:0]; m_cnt[c] = wd[15:0]; m_pc[c] = 0; m_run[c] = 0; end
          3: m_snap[c] = old_cnt;
`ifdef TIMER_PWM_EN
          4: m_cmp[c] = wd[15:0];
`endif
          default: ;
        endcase
    end
  endfunction

  task automatic cyc(input bit cs, input bit wn, input logic [4:0] a, input logic [31:0] wd);
    logic [NC-1:0] ev;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    m_step(cs, wn, a, wd);
    #1;
    for (int c = 0; c < NC; c++) ev[c] = m_to[c] & m_ito[c];
    check("rd", readdata, exp_rd);
    check("irq_vec", 32'(irq_vec), 32'(ev));
    check("irq", 32'(irq), 32'(|ev));
`ifdef TIMER_PWM_EN
    for (int c = 0; c < NC; c++) ev[c] = m_run[c] && m_cnt[c] <= m_cmp[c];
    check("pwm", 32'(pwm_out), 32'(ev));
`endif
  endtask

  task automatic wr(input int ch, input int ra, input logic [31:0] d);
    cyc(1, 0, 5'((ch << 3) | ra), d);
  endtask
  task automatic rd(input int ch, input int ra);
    cyc(1, 1, 5'((ch << 3) | ra), 0);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 1, 0, 0);
  endtask

  initial begin
    int n;
    m_reset();
    #1 reset_n = 0;
    #19;
    check("rst_rd", readdata, 0);
    check("rst_irq", 32'(irq), 0);
    #1 reset_n = 1;
    rd(0, 2); check("t1_per", readdata, 9);
    rd(0, 0); check("t1_st", readdata, 0);
    wr(1, 2, 4); wr(1, 1, 32'h7);
    idle(12);
    check("t2_irq", 32'(irq), 1);
    wr(1, 1, 32'h9); wr(1, 0, 0);
    check("t2_clr", 32'(irq), 0);
    wr(2, 2, 2); wr(2, 1, 32'h305);
    idle(16);
    rd(2, 0); check("t3_st", readdata, 1);
    wr(2, 3, 0); rd(2, 3); check("t3_reload", readdata, 2);
    wr(1, 2, 0); wr(1, 1, 32'h6); idle(2);
    wr(1, 0, 0); rd(1, 0); check("t4_to_wins", readdata, 3);
    wr(1, 1, 32'h8); wr(1, 0, 0); rd(1, 0); check("t4_stopped", readdata, 0);
    wr(1, 1, 32'hC); rd(1, 0); check("t4_start_wins", readdata, 2);
    wr(0, 2, 20); wr(0, 1, 32'h4); idle(13);
    wr(0, 3, 0); idle(2); rd(0, 3); check("t5_snap", readdata, 7);
    wr(3, 2, 5); rd(3, 2); check("t5_bad_ch", readdata, 0);
    wr(0, 2, 9); wr(0, 4, 4); wr(0, 1, 32'h6);
`ifdef TIMER_PWM_EN
    n = 0;
    for (int k = 0; k < 20; k++) begin idle(1); n += int'(pwm_out[0]); end
    check("t6_duty", 32'(n), 10);
`else
    rd(0, 4); check("t6_reg4", readdata, 0);
`endif
    for (int k = 0; k < 3000; k++) begin
      int ch = $urandom_range(0, 3);
      int ra = $urandom_range(0, 7);
      logic [31:0] d = $urandom;
      if (ra == 2 || ra == 4) d = $urandom_range(0, 12);
      if (ra == 1) d = ($urandom_range(0, 3) << 8) | ($urandom & 15);
      if ($urandom_range(0, 9) < 4) idle(1);
      else cyc(1'($urandom), 1'($urandom), 5'((ch << 3) | ra), d);
    end
    wr(1, 2, 0); wr(1, 1, 32'h5); idle(3);
    rd(1, 1);
    check("pre_rst_irq", 32'(irq), 1);
    #2 reset_n = 0;
    #1;
    check("async_rd", readdata, 0);
    check("async_irq", 32'(irq), 0);
    check("async_vec", 32'(irq_vec), 0);
    m_reset();
    #10 reset_n = 1;
    rd(0, 2); check("post_rst_per", readdata, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
